// File: rtl/zoom_window_address_generator_pkg.sv
// Shared types and helpers for the digital-zoom address generator.
// Provides the zoom shift type, default saturation and window sizing.
package zoom_pkg;

    typedef logic [1:0] zoom_shift_t;

    // Default largest log2 zoom (4x).
    localparam zoom_shift_t ZOOM_SHIFT_SAT = 2'd2;

    // Window parameters captured at a frame/line start.
    typedef struct packed {
        zoom_shift_t z;
        logic [11:0] ox;
        logic [10:0] oy;
    } zoom_params_t;

    function automatic zoom_shift_t sat_shift(
        input zoom_shift_t sel,
        input zoom_shift_t lim
    );
        return (sel > lim) ? lim : sel;
    endfunction

    function automatic int win_size(
        input int          out_size,
        input zoom_shift_t z
    );
        return out_size >> z;
    endfunction

endpackage

// File: rtl/zoom_window_address_generator_if.sv
// Pixel request / address response bundle of the zoom address generator.
// master: drives incr/zoom/centre, receives addr_out, valid_out, tuser_out, tlast_out.
// slave: the generator side.
interface zoom_window_address_generator_if #(
    parameter int ADDR_WIDTH = 27
);
    logic                  incr_in;
    logic [1:0]            zoom_sel_in;
    logic [11:0]           center_x_in;
    logic [10:0]           center_y_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  valid_out;
    logic                  tuser_out;
    logic                  tlast_out;

    modport master (
        output incr_in, zoom_sel_in, center_x_in, center_y_in,
        input  addr_out, valid_out, tuser_out, tlast_out
    );

    modport slave (
        input  incr_in, zoom_sel_in, center_x_in, center_y_in,
        output addr_out, valid_out, tuser_out, tlast_out
    );

endinterface

// File: rtl/zoom_window_address_generator_clamp.sv
// Combinational window origin: saturates the zoom, subtracts the half
// window from the centre and clamps the origin inside the source frame.
// Ports: zoom_sel, center_x, center_y in; params (z, ox, oy) out.
module zoom_window_clamp
    import zoom_pkg::*;
#(
    parameter int SRC_WIDTH      = 1920,
    parameter int SRC_HEIGHT     = 1080,
    parameter int OUT_WIDTH      = 1280,
    parameter int OUT_HEIGHT     = 720,
    parameter int ZOOM_SHIFT_MAX = int'(ZOOM_SHIFT_SAT)
) (
    input  logic [1:0]   zoom_sel,
    input  logic [11:0]  center_x,
    input  logic [10:0]  center_y,
    output zoom_params_t params
);

    zoom_shift_t        z;
    logic signed [12:0] half_w;
    logic signed [12:0] lim_x;
    logic signed [12:0] dx;
    logic signed [11:0] half_h;
    logic signed [11:0] lim_y;
    logic signed [11:0] dy;

    always_comb begin
        z      = sat_shift(zoom_sel, zoom_shift_t'(ZOOM_SHIFT_MAX));
        half_w = 13'(win_size(OUT_WIDTH, z) / 2);
        lim_x  = 13'(SRC_WIDTH - win_size(OUT_WIDTH, z));
        half_h = 12'(win_size(OUT_HEIGHT, z) / 2);
        lim_y  = 12'(SRC_HEIGHT - win_size(OUT_HEIGHT, z));
        // one extra sign bit so a centre near 0 goes negative, not wraps
        dx     = $signed({1'b0, center_x}) - half_w;
        dy     = $signed({1'b0, center_y}) - half_h;

        params.z = z;
        if (dx[12])
            params.ox = '0;
        else if (dx > lim_x)
            params.ox = lim_x[11:0];
        else
            params.ox = dx[11:0];

        if (dy[11])
            params.oy = '0;
        else if (dy > lim_y)
            params.oy = lim_y[10:0];
        else
            params.oy = dy[10:0];
    end

endmodule

// File: rtl/zoom_window_address_generator.sv
// Digital-zoom frame-buffer address generator: output counters, window
// parameter latch, 2-stage address pipeline and tuser/tlast sideband.
// Ports: clk_in, rst_in (sync, active-high), bus (slave modport).
// Build option ZOOM_FRAME_LATCH_EN: latch window only at frame start;
// otherwise the window re-latches at every line start.
module zoom_window_address_generator
    import zoom_pkg::*;
#(
    parameter int SRC_WIDTH      = 1920,
    parameter int SRC_HEIGHT     = 1080,
    parameter int OUT_WIDTH      = 1280,
    parameter int OUT_HEIGHT     = 720,
    parameter int ZOOM_SHIFT_MAX = int'(ZOOM_SHIFT_SAT),
    parameter int ADDR_WIDTH     = 27
) (
    input logic clk_in,
    input logic rst_in,
    zoom_window_address_generator_if.slave bus
);

    localparam int HW = $clog2(OUT_WIDTH);
    localparam int VW = $clog2(OUT_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SRC_WIDTH);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          h_last;
    logic          v_last;
    logic          frame_start;
    logic          capture;

    zoom_params_t  fresh;
    zoom_params_t  held;
    zoom_params_t  eff;

    logic [10:0]   row1;
    logic [11:0]   col1;
    logic          v1;
    logic          tu1;
    logic          tl1;

    zoom_window_clamp #(
        .SRC_WIDTH      (SRC_WIDTH),
        .SRC_HEIGHT     (SRC_HEIGHT),
        .OUT_WIDTH      (OUT_WIDTH),
        .OUT_HEIGHT     (OUT_HEIGHT),
        .ZOOM_SHIFT_MAX (ZOOM_SHIFT_MAX)
    ) u_clamp (
        .zoom_sel (bus.zoom_sel_in),
        .center_x (bus.center_x_in),
        .center_y (bus.center_y_in),
        .params   (fresh)
    );

    assign h_last      = (hcount == HW'(OUT_WIDTH - 1));
    assign v_last      = (vcount == VW'(OUT_HEIGHT - 1));
    assign frame_start = (hcount == '0) && (vcount == '0);

`ifdef ZOOM_FRAME_LATCH_EN
    assign capture = bus.incr_in && frame_start;
`else
    assign capture = bus.incr_in && (hcount == '0);
`endif

    // the capturing pixel already uses the freshly computed window
    assign eff = capture ? fresh : held;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcount <= '0;
            vcount <= '0;
            held   <= '0;
        end else if (bus.incr_in) begin
            if (capture)
                held <= fresh;
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // stage 1: source row/column
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row1 <= '0;
            col1 <= '0;
            v1   <= 1'b0;
            tu1  <= 1'b0;
            tl1  <= 1'b0;
        end else begin
            v1 <= bus.incr_in;
            if (bus.incr_in) begin
                row1 <= eff.oy + 11'(vcount >> eff.z);
                col1 <= eff.ox + 12'(hcount >> eff.z);
                tu1  <= frame_start;
                tl1  <= h_last;
            end
        end
    end

    // stage 2: linear address
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.addr_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.tuser_out <= 1'b0;
            bus.tlast_out <= 1'b0;
        end else begin
            bus.valid_out <= v1;
            bus.tuser_out <= v1 && tu1;
            bus.tlast_out <= v1 && tl1;
            if (v1)
                bus.addr_out <= ADDR_WIDTH'(row1) * STRIDE
                              + ADDR_WIDTH'(col1);
        end
    end

endmodule

// File: tb/tb_zoom_window_address_generator.sv
// Scoreboard bench for zoom_window_address_generator: directed windows
// with hand-computed origins, latency, sideband and reset behaviour.
module tb_zoom_window_address_generator;

    typedef struct {
        longint addr;
        bit     tuser;
        bit     tlast;
        longint issue;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;
    exp_t   q[$];

    // bench model: counters plus latched hand-computed window
    int mh, mv, lz, lox, loy;
    int pz, pox, poy;

    zoom_window_address_generator_if #(.ADDR_WIDTH(27)) bus ();

    zoom_window_address_generator dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.valid_out === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 expected=0 addr=%0d",
                         bus.addr_out);
            end else begin
                e = q.pop_front();
                chk("addr", 64'(bus.addr_out), 64'(e.addr));
                chk("tuser", 64'(bus.tuser_out), 64'(e.tuser));
                chk("tlast", 64'(bus.tlast_out), 64'(e.tlast));
                chk("latency", 64'(cyc - e.issue), 64'd2);
            end
        end
    end

    task automatic model_reset();
        mh = 0; mv = 0; lz = 0; lox = 0; loy = 0;
    endtask

    task automatic pend(input int z, input int ox, input int oy);
        pz = z; pox = ox; poy = oy;
    endtask

    task automatic drive(input int zs, input int cx, input int cy);
        bus.zoom_sel_in = 2'(zs);
        bus.center_x_in = 12'(cx);
        bus.center_y_in = 11'(cy);
    endtask

    task automatic step(input bit inc);
        exp_t e;
        bit   cap;
        bus.incr_in = inc;
        if (inc && !rst) begin
`ifdef ZOOM_FRAME_LATCH_EN
            cap = (mh == 0 && mv == 0);
`else
            cap = (mh == 0);
`endif
            if (cap) begin
                lz = pz; lox = pox; loy = poy;
            end
            e.addr  = longint'((loy + (mv >> lz)) * 1920 + lox + (mh >> lz));
            e.tuser = (mh == 0 && mv == 0);
            e.tlast = (mh == 1279);
            e.issue = cyc;
            q.push_back(e);
            if (mh == 1279) begin
                mh = 0;
                mv = (mv == 719) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        bus.incr_in = 1'b0;
        repeat (3) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        q.delete();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.incr_in = 1'b0;
        drive(0, 960, 540);
        model_reset();
        pend(0, 320, 180);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(bus.addr_out), 64'd0);
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_tuser", 64'(bus.tuser_out), 64'd0);
        chk("rst_tlast", 64'(bus.tlast_out), 64'd0);
        rst = 1'b0;

        // 1x centre: origin (320,180), one full line
        drive(0, 960, 540); pend(0, 320, 180);
        run(1280);

        // 2x centre: origin (640,360), into line 2
        restart();
        drive(1, 960, 540); pend(1, 640, 360);
        run(2 * 1280 + 3);

        // 4x bottom-right corner clamps to (1600,900)
        restart();
        drive(2, 1919, 1079); pend(2, 1600, 900);
        run(8);

        // 1x top-left corner clamps to (0,0)
        restart();
        drive(0, 0, 0); pend(0, 0, 0);
        run(8);

        // zoom_sel 3 saturates to 4x
        restart();
        drive(3, 1919, 1079); pend(2, 1600, 900);
        run(8);

        // centre moved mid-line: new origin (360,240)
        restart();
        drive(0, 960, 540); pend(0, 320, 180);
        run(100);
        drive(0, 1000, 600); pend(0, 360, 240);
        run(1180 + 10);

        // toggling incr with reset pulsed mid-line
        restart();
        drive(0, 960, 540); pend(0, 320, 180);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        rst = 1'b1;
        step(1'b1);
        q.delete();
        model_reset();
        rst = 1'b0;
        chk("post_rst_valid0", 64'(bus.valid_out), 64'd0);
        step(1'b1);
        chk("post_rst_valid1", 64'(bus.valid_out), 64'd0);
        step(1'b0); step(1'b1); step(1'b0);

        bus.incr_in = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) step(1'b0);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zoom_window_address_generator.md
# zoom_window_address_generator

Parametrised digital-zoom address generator for the top-camera display path. For every output pixel it produces the linear frame-buffer read address of the source pixel covering that position. The read window is centred on a requested point, scaled by a selectable power-of-two zoom, and clamped inside the source frame. It sits between the frame-buffer read port and the AXI-stream video output, and adds frame-start and end-of-line sideband.

## Interface
Parameters:
- SRC_WIDTH, 1920: source frame width in pixels; this is also the frame-buffer row stride.
- SRC_HEIGHT, 1080: source frame height in pixels.
- OUT_WIDTH, 1280: output line length in pixels.
- OUT_HEIGHT, 720: output lines per frame.
- ZOOM_SHIFT_MAX, 2: largest supported log2 zoom factor.
- ADDR_WIDTH, 27: width of the address output.

Ports:
- clk_in, input, 1: the single clock.
- rst_in, input, 1: reset, synchronous and active-high.
- incr_in, input, 1: consume one output pixel position this cycle.
- zoom_sel_in, input, 2: log2 zoom (0 = 1x, 1 = 2x, 2 = 4x).
- center_x_in, input, 12: requested window centre column.
- center_y_in, input, 11: requested window centre row.
- addr_out, output, ADDR_WIDTH: source frame-buffer address.
- valid_out, output, 1: addr_out and sideband are valid this cycle.
- tuser_out, output, 1: first pixel of a frame.
- tlast_out, output, 1: last pixel of a line.

## Operation
- Internal output counters:
  - hcount: 0..OUT_WIDTH-1.
  - vcount: 0..OUT_HEIGHT-1.
  - The counters advance only on incr_in; no state machine beyond these counters and the parameter latch.
- Counter stepping on each incr_in:
  - hcount increments.
  - When hcount = OUT_WIDTH-1, hcount wraps to 0 and vcount increments.
  - When hcount = OUT_WIDTH-1 and vcount = OUT_HEIGHT-1, both wrap to 0.
- Zoom clamp: zoom_sel_in values above ZOOM_SHIFT_MAX saturate to ZOOM_SHIFT_MAX. z denotes the effective shift.
- Window size:
  - ww = OUT_WIDTH >> z.
  - wh = OUT_HEIGHT >> z.
- Window origin:
  - ox = clamp(center_x - ww/2, 0, SRC_WIDTH - ww).
  - oy = clamp(center_y - wh/2, 0, SRC_HEIGHT - wh).
  - Computed signed, one bit wider than the inputs, so a negative difference clamps to 0.
- Address: addr = (oy + (vcount >> z)) * SRC_WIDTH + ox + (hcount >> z), zero-extended to ADDR_WIDTH. No overflow is possible when the parameters are legal.
- Parameter latch:
  - z, ox and oy are captured on the incr_in cycle where hcount = 0 and vcount = 0.
  - The captured values apply to that pixel and to the rest of the frame.
- Sideband:
  - tuser_out marks the pixel at (0,0).
  - tlast_out marks every pixel with hcount = OUT_WIDTH-1.
- Stalls: incr_in low holds all counters and latches. No valid_out is produced for that slot.

## Timing
- Latency: exactly 2 cycles from incr_in to the matching valid_out, addr_out, tuser_out and tlast_out.
- Fully pipelined: one address per cycle under continuous incr_in.
- Outputs are registered.
- Reset values:
  - addr_out, valid_out, tuser_out and tlast_out are 0.
  - hcount and vcount are 0.
  - Latched z, ox and oy are 0.
  - Pipeline valid bits are cleared.
- Reset mid-frame:
  - In-flight addresses are dropped; no valid_out appears for 2 cycles after rst_in falls.
  - The next incr_in is treated as the frame start and re-latches the parameters.
- Simultaneous events: an input change in the same cycle as the frame-start incr_in is captured.
- Changes at any other time have no effect until the next frame start.

## Configuration
- Macro: ZOOM_FRAME_LATCH_EN.
- Defined: z, ox and oy latch only at frame start, as described in Operation. This gives tear-free panning.
- Undefined:
  - Parameters re-latch at every line start (hcount = 0 with incr_in).
  - Centre and zoom changes take effect on the next line.
  - The vcount >> z row mapping keeps using the frame-relative vcount.

## Structure
- Package zoom_pkg:
  - typedef zoom_shift_t (2 bits).
  - Saturation constant for ZOOM_SHIFT_MAX.
  - Function computing window size from output size and shift.
- Sub-module zoom_window_clamp: combinational origin computation (zoom saturation, half-window subtract, two-sided clamp) producing ox and oy. It is instantiated once and its outputs feed the latch.
- The top level holds the counters, the parameter latch, the 2-stage address pipeline and the sideband delay.

## Test plan
- 1x, centre (960,540), continuous incr_in:
  - First valid_out 2 cycles after the first incr_in, with addr 345920 and tuser_out=1.
  - Pixel 1279 gives addr 347199 with tlast_out=1.
- 2x, centre (960,540):
  - Pixels 0 and 1 give addr 691840.
  - Pixel 2 gives 691841.
  - Line 2, pixel 0 gives 693760.
- 4x, centre (1919,1079): origin clamps to (1600,900) and the first addr is 1729600.
- 1x, centre (0,0): origin clamps to (0,0) and the first addr is 0.
- zoom_sel_in = 3: behaves as 4x.
- Centre changed mid-frame (ZOOM_FRAME_LATCH_EN defined):
  - Addresses are unchanged until the next tuser_out pixel.
  - The new origin applies from that pixel on.
- incr_in toggling 1,0,1 with rst_in pulsed mid-line:
  - valid_out follows each incr_in 2 cycles later with no gaps filled.
  - After reset, the next pixel is (0,0) with tuser_out=1.
